// File: rtl/pkt_drain_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pkt_drain_dispatch: drains one FWFT-FIFO packet per queued action,          |
// | forwarding it tagged with its port or discarding it.                        |
// | Optional build macro PKT_DRAIN_STATS_EN adds fwd_cnt/drop_cnt.  Rev 1.0     |
// +----------------------------------------------------------------------------+
module pkt_drain_dispatch #(
  parameter int ACTION_W  = 64,
  parameter int DATA_W    = 64,
  parameter int PORT_W    = 4,
  parameter int ACT_DEPTH = 4,
  parameter int SOP_CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                allow_drain,
  input  logic [ACTION_W-1:0] action_latched,
  input  logic                pkt_start_latched,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_dout,
  input  logic                fifo_eop,
  output logic                fifo_rd_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic [PORT_W-1:0]   out_port,
  output logic                busy,
  output logic                err_act_ovf,
  output logic                err_sop_ovf
`ifdef PKT_DRAIN_STATS_EN
  ,
  output logic [31:0]         fwd_cnt,
  output logic [31:0]         drop_cnt
`endif
);

  localparam int ACT_AW = (ACT_DEPTH > 1) ? $clog2(ACT_DEPTH) : 1;
  localparam int ENT_W  = PORT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Only the drop flag and port field of an action are ever used.
  logic [ENT_W-1:0]  act_mem [ACT_DEPTH];
  logic [ACT_AW:0]   wr_ptr;
  logic [ACT_AW:0]   rd_ptr;
  logic [ENT_W-1:0]  head;
  logic              q_empty;
  logic              q_full;
  logic              push;
  logic              launch;

  logic [SOP_CNT_W-1:0] sop_pend;
  logic                 first;
  logic                 fwd_valid;
  logic                 fwd_take;
  logic                 drop_take;

  generate
    if (ACTION_W > ENT_W) begin : g_act_unused
      logic unused_act_bits;
      assign unused_act_bits = ^action_latched[ACTION_W-1:ENT_W];
    end
  endgenerate

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[ACT_AW] != rd_ptr[ACT_AW]) &&
                   (wr_ptr[ACT_AW-1:0] == rd_ptr[ACT_AW-1:0]);
  assign head    = act_mem[rd_ptr[ACT_AW-1:0]];
  assign push    = allow_drain && (!q_full || launch);

  always_ff @(posedge clk) begin
    if (push) begin
      act_mem[wr_ptr[ACT_AW-1:0]] <= action_latched[ENT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err_act_ovf <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{ACT_AW{1'b0}}, 1'b1};
      end
      if (launch) begin
        rd_ptr <= rd_ptr + {{ACT_AW{1'b0}}, 1'b1};
      end
      if (allow_drain && q_full && !launch) begin
        err_act_ovf <= 1'b1;
      end
    end
  end

  // Pending-SOP count: simultaneous increment and launch cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sop_pend    <= '0;
      err_sop_ovf <= 1'b0;
    end else begin
      case ({pkt_start_latched, launch})
        2'b10: begin
          if (sop_pend == {SOP_CNT_W{1'b1}}) begin
            err_sop_ovf <= 1'b1;
          end else begin
            sop_pend <= sop_pend + {{(SOP_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        2'b01:   sop_pend <= sop_pend - {{(SOP_CNT_W-1){1'b0}}, 1'b1};
        default: sop_pend <= sop_pend;
      endcase
    end
  end

  assign fwd_valid = (state == FWD) && !fifo_empty;
  assign fwd_take  = fwd_valid && out_ready;
  assign drop_take = (state == DROP) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    launch     = 1'b0;
    fifo_rd_en = 1'b0;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty && (sop_pend != '0) && !fifo_empty) begin
          launch   = 1'b1;
          state_nx = head[0] ? DROP : FWD;
        end
      end
      FWD: begin
        out_valid  = fwd_valid;
        out_sop    = fwd_valid && first;
        fifo_rd_en = fwd_take;
        if (fwd_take && fifo_eop) begin
          state_nx = IDLE;
        end
      end
      DROP: begin
        fifo_rd_en = drop_take;
        if (drop_take && fifo_eop) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_port <= '0;
      first    <= 1'b1;
    end else if (launch) begin
      out_port <= head[PORT_W:1];
      first    <= 1'b1;
    end else if (fwd_take) begin
      first    <= 1'b0;
    end
  end

  assign out_data = fifo_dout;
  assign out_eop  = fifo_eop;
  assign busy     = (state != IDLE);

`ifdef PKT_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd_take && fifo_eop) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
      if (drop_take && fifo_eop) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
